// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmitter and receiver.
// Honours macro RS232_XMTR_PARITY_EN, which adds an even-parity bit to each frame.
package rs232_pkg;

  localparam int RS232_DATA_BITS = 8;
`ifdef RS232_XMTR_PARITY_EN
  localparam int RS232_FRAME_BITS = 11;
`else
  localparam int RS232_FRAME_BITS = 10;
`endif

  // 25 MHz system clock: 19200 baud and 115200 baud.
  localparam int RS232_SLOW_DIV = 1302;
  localparam int RS232_FAST_DIV = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RS232_XMTR_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  // Larger of the two divisors; sizes the shared baud counter.
  function automatic int max_div(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-time generator: counts 0..DIV-1 using one of two divisors and pulses
// tick on the last count. clear holds the count at 0 so the first bit time
// after release is a full DIV clocks. Shared by transmitter and receiver.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter int SLOW_DIV = RS232_SLOW_DIV,
  parameter int FAST_DIV = RS232_FAST_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sel,
  output logic tick
);

  localparam int CNT_W = $clog2(max_div(SLOW_DIV, FAST_DIV));
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last = sel ? FAST_LAST : SLOW_LAST;
  assign tick = (cnt == last);

  // Free-running divider, restarted by clear and wrapped at the last count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rs232_xmtr.sv
// RS-232 transmitter: one byte per start strobe, sent LSB first as an
// asynchronous 8N1 frame on txd. fsel picks the bit divisor at frame start.
// Macro RS232_XMTR_PARITY_EN inserts an even-parity bit before the stop bit.
module rs232_xmtr
  import rs232_pkg::*;
#(
  parameter int SLOW_DIV = RS232_SLOW_DIV,
  parameter int FAST_DIV = RS232_FAST_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fsel,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       txd
);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       div_sel;
  logic       tick;
  logic       baud_clear;
`ifdef RS232_XMTR_PARITY_EN
  logic       parity_q;
`endif

  // The divider idles at zero, so the start bit is a full bit time long.
  assign baud_clear = (state == IDLE);

  rs232_baud_tick #(
    .SLOW_DIV(SLOW_DIV),
    .FAST_DIV(FAST_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .sel  (div_sel),
    .tick (tick)
  );

  // Frame sequencer; txd and rdy are registered so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_sel  <= 1'b0;
      rdy      <= 1'b1;
      txd      <= 1'b1;
`ifdef RS232_XMTR_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= data;
            div_sel  <= fsel;
            bit_cnt  <= '0;
`ifdef RS232_XMTR_PARITY_EN
            parity_q <= ^data;
`endif
            state    <= START;
            rdy      <= 1'b0;
            txd      <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
`ifdef RS232_XMTR_PARITY_EN
              state <= PARITY;
              txd   <= parity_q;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef RS232_XMTR_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_xmtr.sv
// Self-checking bench for rs232_xmtr with SLOW_DIV=16, FAST_DIV=4.
// A frame-level model predicts txd/rdy every cycle; directed frames are also
// checked against hand-written bit sequences.
module tb_rs232_xmtr;

  localparam int SDIV = 16;
  localparam int FDIV = 4;
`ifdef RS232_XMTR_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fsel = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy;
  logic       txd;

  int n_total = 0;
  int n_bad   = 0;

  rs232_xmtr #(
    .SLOW_DIV(SDIV),
    .FAST_DIV(FDIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fsel (fsel),
    .start(start),
    .data (data),
    .rdy  (rdy),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of line levels, one per bit time; the model just counts
  // down the clocks left in the frame and looks up the current bit.
  int          m_rem = 0;
  int          m_div = FDIV;
  logic [10:0] m_bits = '1;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef RS232_XMTR_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
    end else if (start) begin
      m_div  <= fsel ? FDIV : SDIV;
      m_rem  <= FB * (fsel ? FDIV : SDIV);
      m_bits <= frame_of(data);
    end
  end

  // Compare DUT outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    logic exp_txd;
    logic exp_rdy;
    if (m_rem > 0) begin
      exp_txd = m_bits[(FB * m_div - m_rem) / m_div];
      exp_rdy = 1'b0;
    end else begin
      exp_txd = 1'b1;
      exp_rdy = 1'b1;
    end
    check("model txd", 32'(txd), 32'(exp_txd));
    check("model rdy", 32'(rdy), 32'(exp_rdy));
  end

  // ---------------- stimulus helpers ----------------
  logic smp [0:255];
  int   low_cnt;

  // Strobe start for one cycle; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic fs);
    @(posedge clk);
    #1;
    start = 1'b1;
    data  = d;
    fsel  = fs;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = 8'($urandom);
  endtask

  // Record txd for every clock of the frame; optionally pulse start (with
  // random data and fsel) mid-frame, which must have no effect.
  task automatic capture(input int div, input int poke_at);
    low_cnt = 0;
    for (int c = 0; c < FB * div; c++) begin
      @(negedge clk);
      smp[c] = txd;
      if (rdy == 1'b0) low_cnt++;
      if (c == poke_at) begin
        start = 1'b1;
        data  = 8'hFF;
        fsel  = 1'($urandom);
      end else if (c == poke_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  // Every bit must hold its literal level for exactly div clocks.
  task automatic check_frame(input string name, input int div, input logic [10:0] exp);
    for (int i = 0; i < FB; i++) begin
      int cnt;
      cnt = 0;
      for (int j = 0; j < div; j++) if (smp[i * div + j] === exp[i]) cnt++;
      check($sformatf("%s bit%0d clocks", name, i), 32'(cnt), 32'(div));
    end
    check({name, " rdy low clocks"}, 32'(low_cnt), 32'(FB * div));
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rdy) seen = 1'b1;
    end
    if (!seen) check("idle timeout", 32'(rdy), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [10:0] exp_a5, exp_01, exp_00, exp_3c;
`ifdef RS232_XMTR_PARITY_EN
    exp_a5 = 11'b10101001010;
    exp_01 = 11'b11000000010;
    exp_00 = 11'b10000000000;
    exp_3c = 11'b10001111000;
`else
    exp_a5 = 11'b01101001010;
    exp_01 = 11'b01000000010;
    exp_00 = 11'b01000000000;
    exp_3c = 11'b01001111000;
`endif

    // Reset and a quiet idle line.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset rdy", 32'(rdy), 32'd1);
    check("reset txd", 32'(txd), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check("idle100 rdy", 32'(rdy), 32'd1);
    check("idle100 txd", 32'(txd), 32'd1);

    // Fast frame 8'hA5.
    send(8'hA5, 1'b1);
    capture(FDIV, -10);
    check_frame("a5", FDIV, exp_a5);
    @(negedge clk);
    check("a5 rdy back", 32'(rdy), 32'd1);

    // Slow frame 8'h01 with an ignored start at clock 20.
    send(8'h01, 1'b0);
    capture(SDIV, 20);
    check_frame("s01", SDIV, exp_01);
    wait_idle(4);

    // Back-to-back: start in the first rdy=1 cycle after frame 8'h00.
    send(8'h00, 1'b1);
    capture(FDIV, -10);
    check_frame("b2b", FDIV, exp_00);
    @(negedge clk);
    check("b2b rdy cycle", 32'(rdy), 32'd1);
    check("b2b idle txd", 32'(txd), 32'd1);
    start = 1'b1;
    data  = 8'h81;
    fsel  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b next start txd", 32'(txd), 32'd0);
    check("b2b next start rdy", 32'(rdy), 32'd0);
    wait_idle(100);

    // Reset during data bit 3 (frame clocks 16..19 at DIV=4).
    send(8'($urandom), 1'b1);
    repeat (18) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst txd", 32'(txd), 32'd1);
    check("midrst rdy", 32'(rdy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h3C, 1'b1);
    capture(FDIV, -10);
    check_frame("3c", FDIV, exp_3c);
    wait_idle(4);

`ifdef RS232_XMTR_PARITY_EN
    send(8'h07, 1'b1);
    capture(FDIV, -10);
    check_frame("p07", FDIV, 11'b11000001110);
    wait_idle(4);
    send(8'h03, 1'b1);
    capture(FDIV, -10);
    check_frame("p03", FDIV, 11'b10000000110);
    wait_idle(4);
`endif

    // Random frames with random ignored strobes; checked by the model.
    for (int k = 0; k < 30; k++) begin
      logic fs;
      int   div;
      fs  = 1'($urandom);
      div = fs ? FDIV : SDIV;
      send(8'($urandom), fs);
      capture(div, ($urandom_range(0, 3) == 0) ? -10 : int'($urandom_range(0, FB * div - 3)));
      wait_idle(4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
